// File: rtl/tx_pkg.sv
// Shared definitions for the transmit burst shaper: burst FSM states and the
// sample-path latency from accept to shaped output.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    ON,
    RAMP_DOWN,
    GUARD
  } tx_state_t;

  localparam int TX_SHAPE_LAT = 2;

  // States in which the transmitter is keyed and samples flow from upstream.
  function automatic logic is_active(tx_state_t s);
    return (s == RAMP_UP) || (s == ON) || (s == RAMP_DOWN);
  endfunction

endpackage

// File: rtl/ramp_scaler.sv
// Signed sample times unsigned gain, arithmetic shift by the ramp exponent.
// Two register stages: product, then shifted/truncated output.
module ramp_scaler #(
  parameter int WIDTH      = 16,
  parameter int RAMP_WIDTH = 8,
  parameter int SHIFT_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] din,
  input  logic [RAMP_WIDTH-1:0]   gain,
  input  logic [SHIFT_W-1:0]      shift,
  output logic signed [WIDTH-1:0] dout
);

  localparam int PROD_W = WIDTH + RAMP_WIDTH + 1;

  logic signed [RAMP_WIDTH:0] gain_s;
  logic signed [PROD_W-1:0]   prod;
  logic [SHIFT_W-1:0]         shift_q;

  assign gain_s = {1'b0, gain};

  // The shift travels with its product so a later config change cannot
  // reinterpret a sample already in flight.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    if (rst) begin
      prod    <= '0;
      shift_q <= '0;
      dout    <= '0;
    end else begin
      prod    <= PROD_W'(din) * PROD_W'(gain_s);
      shift_q <= shift;
      dout    <= WIDTH'(prod >>> shift_q);
    end
  end

endmodule

// File: rtl/tx_burst_shaper.sv
// Burst gate between modulator and DAC: linear gain ramp up/down around each
// burst, followed by a zero-output guard interval.
module tx_burst_shaper
  import tx_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int RAMP_WIDTH  = 8,
  parameter int GUARD_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              TX_RAMP_SHIFT,
  input  logic [GUARD_WIDTH-1:0]  TX_GUARD_LEN,
  input  logic                    tx_en,
  input  logic signed [WIDTH-1:0] I_tdata,
  input  logic signed [WIDTH-1:0] Q_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic signed [WIDTH-1:0] I_out,
  output logic signed [WIDTH-1:0] Q_out,
  output logic                    out_tvalid,
  output logic                    tx_active,
  output logic                    busy
);

  localparam int SHIFT_W = (RAMP_WIDTH > 1) ? $clog2(RAMP_WIDTH) : 1;
  localparam int K_MAX   = RAMP_WIDTH - 1;

  tx_state_t              state, state_n;
  logic [RAMP_WIDTH-1:0]  gain, gain_n;
  logic [SHIFT_W-1:0]     k_q, k_n, k_sat;
  logic [GUARD_WIDTH-1:0] guard_len, glen_n;
  logic [GUARD_WIDTH-1:0] guard_cnt, gcnt_n;
  logic [GUARD_WIDTH:0]   gcnt_inc;
  logic [RAMP_WIDTH-1:0]  full, gain_inc, gain_dec, scale_gain;
  logic                   scale_valid;
  logic                   accept;
  logic                   active_q;
  logic [TX_SHAPE_LAT-1:0] vld_pipe;

  assign k_sat    = (int'(TX_RAMP_SHIFT) > K_MAX) ? SHIFT_W'(K_MAX) : SHIFT_W'(TX_RAMP_SHIFT);
  assign full     = RAMP_WIDTH'(1) << k_q;
  assign gain_inc = gain + RAMP_WIDTH'(1);
  assign gain_dec = gain - RAMP_WIDTH'(1);
  assign gcnt_inc = {1'b0, guard_cnt} + (GUARD_WIDTH + 1)'(1);
  assign accept   = s_tvalid & s_tready;

  assign s_tready   = active_q;
  assign tx_active  = active_q;
  assign out_tvalid = vld_pipe[TX_SHAPE_LAT-1];

  always_comb begin
    // NOTE: every signal written here is defaulted first, so no branch can
    // leave it holding a value and infer a latch.
    state_n     = state;
    gain_n      = gain;
    k_n         = k_q;
    glen_n      = guard_len;
    gcnt_n      = '0;
    scale_valid = 1'b0;
    scale_gain  = '0;

    case (state)
      IDLE: begin
        scale_valid = 1'b1;
        gain_n      = '0;
        if (tx_en) begin
          state_n = RAMP_UP;
          k_n     = k_sat;
          glen_n  = TX_GUARD_LEN;
        end
      end

      RAMP_UP: begin
        if (accept) begin
          scale_valid = 1'b1;
          scale_gain  = gain_inc;
          gain_n      = gain_inc;
        end
        // Dropping tx_en mid-ramp folds back from the gain reached so far.
        if (!tx_en) begin
          state_n = (gain_n <= RAMP_WIDTH'(1)) ? GUARD : RAMP_DOWN;
        end else if (gain_n == full) begin
          state_n = ON;
        end
      end

      ON: begin
        if (accept) begin
          scale_valid = 1'b1;
          scale_gain  = full;
        end
        if (!tx_en) begin
          state_n = (full <= RAMP_WIDTH'(1)) ? GUARD : RAMP_DOWN;
        end
      end

      RAMP_DOWN: begin
        if (accept) begin
          scale_valid = 1'b1;
          scale_gain  = gain_dec;
          gain_n      = gain_dec;
          if (gain_dec <= RAMP_WIDTH'(1)) begin
            state_n = GUARD;
          end
        end
      end

      GUARD: begin
        scale_valid = 1'b1;
        gcnt_n      = gcnt_inc[GUARD_WIDTH-1:0];
        if (gcnt_inc >= {1'b0, guard_len}) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gain      <= '0;
      k_q       <= '0;
      guard_len <= '0;
      guard_cnt <= '0;
      active_q  <= 1'b0;
      busy      <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      state     <= state_n;
      gain      <= gain_n;
      k_q       <= k_n;
      guard_len <= glen_n;
      guard_cnt <= gcnt_n;
      active_q  <= is_active(state_n);
      busy      <= (state_n != IDLE);
      vld_pipe  <= {vld_pipe[TX_SHAPE_LAT-2:0], scale_valid};
    end
  end

  // Idle and guard cycles push gain 0 through the same pipe, giving aligned zero fill.
  ramp_scaler #(
    .WIDTH     (WIDTH),
    .RAMP_WIDTH(RAMP_WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_scale_i (
    .clk  (clk),
    .rst  (rst),
    .din  (I_tdata),
    .gain (scale_gain),
    .shift(k_q),
    .dout (I_out)
  );

  ramp_scaler #(
    .WIDTH     (WIDTH),
    .RAMP_WIDTH(RAMP_WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_scale_q (
    .clk  (clk),
    .rst  (rst),
    .din  (Q_tdata),
    .gain (scale_gain),
    .shift(k_q),
    .dout (Q_out)
  );

endmodule

// File: tb/tb_tx_burst_shaper.sv
// Scoreboard bench for tx_burst_shaper: each driven cycle queues the output
// expected two clocks later; state-level outputs are checked in the same cycle.
module tb_tx_burst_shaper;

  localparam int WIDTH       = 16;
  localparam int RAMP_WIDTH  = 8;
  localparam int GUARD_WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [3:0]              TX_RAMP_SHIFT;
  logic [GUARD_WIDTH-1:0]  TX_GUARD_LEN;
  logic                    tx_en;
  logic signed [WIDTH-1:0] I_tdata, Q_tdata;
  logic                    s_tvalid;
  logic                    s_tready;
  logic signed [WIDTH-1:0] I_out, Q_out;
  logic                    out_tvalid;
  logic                    tx_active;
  logic                    busy;

  tx_burst_shaper #(
    .WIDTH      (WIDTH),
    .RAMP_WIDTH (RAMP_WIDTH),
    .GUARD_WIDTH(GUARD_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .TX_RAMP_SHIFT(TX_RAMP_SHIFT),
    .TX_GUARD_LEN (TX_GUARD_LEN),
    .tx_en        (tx_en),
    .I_tdata      (I_tdata),
    .Q_tdata      (Q_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .I_out        (I_out),
    .Q_out        (Q_out),
    .out_tvalid   (out_tvalid),
    .tx_active    (tx_active),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef enum {ST_IDLE, ST_ACT, ST_GRD} phase_t;

  typedef struct {
    logic                    ev;
    logic signed [WIDTH-1:0] ei;
    logic signed [WIDTH-1:0] eq;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("out_tvalid", out_tvalid, e.ev);
      if (e.ev) begin
        check("I_out", I_out, e.ei);
        check("Q_out", Q_out, e.eq);
      end
    end
  endtask

  // One clock of stimulus. ph is the state class the DUT must be in during
  // this cycle; ei/eq are the shaped values expected if a sample is accepted.
  task automatic step(input logic en, input logic vld,
                      input logic signed [WIDTH-1:0] di, input logic signed [WIDTH-1:0] dq,
                      input phase_t ph,
                      input logic signed [WIDTH-1:0] ei, input logic signed [WIDTH-1:0] eq);
    exp_t e;
    @(negedge clk);
    compare_out();
    check("busy", busy, ph != ST_IDLE);
    check("tx_active", tx_active, ph == ST_ACT);
    check("s_tready", s_tready, ph == ST_ACT);
    rst      = 1'b0;
    tx_en    = en;
    s_tvalid = vld;
    I_tdata  = di;
    Q_tdata  = dq;
    e.ev = (ph != ST_ACT) || vld;
    e.ei = (ph == ST_ACT) ? ei : '0;
    e.eq = (ph == ST_ACT) ? eq : '0;
    sb.push_back(e);
  endtask

  // Holds rst for n clocks; anything in flight is discarded by the DUT.
  task automatic do_reset(input int n);
    exp_t e;
    e.ev = 1'b0;
    e.ei = '0;
    e.eq = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_out();
      if (i > 0) begin
        check("rst_busy", busy, 1'b0);
        check("rst_tx_active", tx_active, 1'b0);
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_I_out", I_out, 0);
      end
      rst      = 1'b1;
      tx_en    = 1'b0;
      s_tvalid = 1'b0;
      if (i == 0) begin
        sb.delete();
        sb.push_back(e);
      end
      sb.push_back(e);
    end
  endtask

  function automatic logic signed [WIDTH-1:0] scaled(input logic signed [WIDTH-1:0] x, input int g, input int k);
    longint p;
    p = longint'(x) * g;
    return WIDTH'(p >>> k);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, ST_IDLE, 0, 0);
  endtask

  initial begin
    rst           = 1'b1;
    tx_en         = 1'b0;
    s_tvalid      = 1'b0;
    I_tdata       = '0;
    Q_tdata       = '0;
    TX_RAMP_SHIFT = 4'd2;
    TX_GUARD_LEN  = 8'd4;

    do_reset(3);
    idle(3);

    // k=2, guard=4: 250/500/750/1000 up, full, then 750/500/250 and 4 guard cycles
    step(1, 0, 0, 0, ST_IDLE, 0, 0);
    step(1, 1, 1000, -1000, ST_ACT, 250, -250);
    TX_RAMP_SHIFT = 4'd5;
    TX_GUARD_LEN  = 8'd0;
    step(1, 1, 1000, -1000, ST_ACT, 500, -500);
    step(1, 1, 1000, -1000, ST_ACT, 750, -750);
    step(1, 1, 1000, -1000, ST_ACT, 1000, -1000);
    step(1, 1, 1000, -1000, ST_ACT, 1000, -1000);
    step(1, 1, 1000, -1000, ST_ACT, 1000, -1000);
    step(0, 1, 1000, -1000, ST_ACT, 1000, -1000);
    step(0, 1, 1000, -1000, ST_ACT, 750, -750);
    step(1, 1, 1000, -1000, ST_ACT, 500, -500);
    step(1, 1, 1000, -1000, ST_ACT, 250, -250);
    for (int i = 0; i < 4; i++) step(1, 1, 1000, -1000, ST_GRD, 0, 0);
    idle(2);

    // k=0: full gain on the first sample, no ramp-down samples, guard=0
    TX_RAMP_SHIFT = 4'd0;
    TX_GUARD_LEN  = 8'd0;
    step(1, 0, 0, 0, ST_IDLE, 0, 0);
    step(1, 1, -32768, 32767, ST_ACT, -32768, 32767);
    step(1, 1, -32768, 32767, ST_ACT, -32768, 32767);
    step(0, 1, -32768, 32767, ST_ACT, -32768, 32767);
    step(0, 0, 0, 0, ST_GRD, 0, 0);
    idle(2);

    // k=3: tx_en dropped at g=3 folds back 300 -> 200 -> 100
    TX_RAMP_SHIFT = 4'd3;
    TX_GUARD_LEN  = 8'd2;
    step(1, 0, 0, 0, ST_IDLE, 0, 0);
    step(1, 1, 800, -800, ST_ACT, 100, -100);
    step(1, 1, 800, -800, ST_ACT, 200, -200);
    step(1, 1, 800, -800, ST_ACT, 300, -300);
    step(0, 0, 800, -800, ST_ACT, 0, 0);
    step(0, 1, 800, -800, ST_ACT, 200, -200);
    step(0, 1, 800, -800, ST_ACT, 100, -100);
    step(0, 1, 800, -800, ST_GRD, 0, 0);
    step(0, 1, 800, -800, ST_GRD, 0, 0);
    idle(2);

    // k=2 with s_tvalid toggling: gain advances only on accepts, no zero insertion
    TX_RAMP_SHIFT = 4'd2;
    TX_GUARD_LEN  = 8'd1;
    step(1, 0, 0, 0, ST_IDLE, 0, 0);
    step(1, 1, 400, -400, ST_ACT, 100, -100);
    step(1, 0, 400, -400, ST_ACT, 0, 0);
    step(1, 1, 400, -400, ST_ACT, 200, -200);
    step(1, 0, 400, -400, ST_ACT, 0, 0);
    step(1, 1, 400, -400, ST_ACT, 300, -300);
    step(1, 0, 400, -400, ST_ACT, 0, 0);
    step(1, 1, 400, -400, ST_ACT, 400, -400);
    step(1, 1, 400, -400, ST_ACT, 400, -400);
    step(0, 0, 400, -400, ST_ACT, 0, 0);
    step(0, 1, 400, -400, ST_ACT, 300, -300);
    step(0, 0, 400, -400, ST_ACT, 0, 0);
    step(0, 1, 400, -400, ST_ACT, 200, -200);
    step(0, 1, 400, -400, ST_ACT, 100, -100);
    step(0, 0, 0, 0, ST_GRD, 0, 0);
    idle(2);

    // Reset while ON: zeros, pipeline flushed, zero fill resumes 2 clocks after release
    TX_RAMP_SHIFT = 4'd1;
    TX_GUARD_LEN  = 8'd3;
    step(1, 0, 0, 0, ST_IDLE, 0, 0);
    step(1, 1, 1000, 1000, ST_ACT, 500, 500);
    step(1, 1, 1000, 1000, ST_ACT, 1000, 1000);
    step(1, 1, 1000, 1000, ST_ACT, 1000, 1000);
    do_reset(2);
    idle(3);

    // Shift 15 saturates to 7: 128-sample ramp, last ramp-up output equals input
    TX_RAMP_SHIFT = 4'd15;
    TX_GUARD_LEN  = 8'd3;
    step(1, 0, 0, 0, ST_IDLE, 0, 0);
    for (int g = 1; g <= 128; g++)
      step(1, 1, 12345, -12345, ST_ACT, scaled(12345, g, 7), scaled(-12345, g, 7));
    step(0, 0, 0, 0, ST_ACT, 0, 0);
    for (int g = 127; g >= 1; g--)
      step(0, 1, 12345, -12345, ST_ACT, scaled(12345, g, 7), scaled(-12345, g, 7));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, ST_GRD, 0, 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
